// File: rtl/mul_unit.sv
// Iterative unsigned multiplier owning the HI/LO pair: shift-and-add, STEP
// multiplier bits retired per cycle, fixed latency WIDTH/STEP cycles.
module mul_unit #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_req,
   input  logic             lohi,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   // Work values after this cycle's STEP sub-steps
   logic [2*WIDTH-1:0] acc_s, mcand_s;
   logic [WIDTH-1:0]   mplier_s;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      acc_s    = acc_q;
      mcand_s  = mcand_q;
      mplier_s = mplier_q;
      for (int i = 0; i < STEP; i++) begin
         if (mplier_s[0]) acc_s = acc_s + mcand_s;
         mcand_s  = mcand_s << 1;
         mplier_s = mplier_s >> 1;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               count_d  = CW'(N);
            end
         end
         RUN: begin
            acc_d    = acc_s;
            mcand_d  = mcand_s;
            mplier_d = mplier_s;
            count_d  = count_q - CW'(1);
            // Last iteration: HI/LO only ever change here
            if (count_q == CW'(1)) begin
               {hi_d, lo_d} = acc_s;
               state_d      = IDLE;
               done_d       = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q == RUN);
   assign done    = done_q;
   assign stall   = busy & (rd_req | start);
   assign rd_data = lohi ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: issued multiplies push their 64-bit product into a
// queue; a monitor pops and compares whenever done pulses.
module tb_mul_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, rd_req, lohi;
  logic [W-1:0] a, b, rd_data;
  logic         busy, done, stall;

  logic         start4, lohi4;
  logic [W-1:0] a4, b4, rd_data4;
  logic         busy4, done4, stall4;

  int           checks = 0;
  int           errors = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  model_hl = '0;
  logic         prev_done = 1'b0;

  mul_unit #(.WIDTH(W), .STEP(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .rd_req(rd_req), .lohi(lohi), .rd_data(rd_data),
    .busy(busy), .done(done), .stall(stall)
  );

  mul_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .rd_req(1'b0), .lohi(lohi4), .rd_data(rd_data4),
    .busy(busy4), .done(done4), .stall(stall4)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {32'b0, rd_data}, lohi ? {32'b0, e[63:32]} : {32'b0, e[31:0]});
        model_hl = e;
      end
      chk("done_pulse_len", {63'b0, prev_done}, 64'd0);
    end
    prev_done = reset & done;
  end

  // driver tasks
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(p);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic read_chk(input string name, input logic sel, input logic [63:0] hl);
    lohi = sel;
    #1;
    chk(name, {32'b0, rd_data}, sel ? {32'b0, hl[63:32]} : {32'b0, hl[31:0]});
  endtask

  // Waits for done; on every busy cycle a pending read/start must stall and
  // a read must still see the previous result.
  task automatic wait_done(input bit rnd, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk("stall_at_done", {63'b0, stall}, 64'd0);
        #2;
        start  = 1'b0;
        rd_req = 1'b0;
      end else begin
        if (busy) cyc++;
        if (busy && (rd_req || start)) chk("stall_busy", {63'b0, stall}, 64'd1);
        if (rd_req) chk("rd_old", {32'b0, rd_data}, lohi ? {32'b0, model_hl[63:32]} : {32'b0, model_hl[31:0]});
        #2;
        if (rnd) begin
          rd_req = 1'($urandom_range(0, 1));
          lohi   = 1'($urandom_range(0, 1));
          start  = ($urandom_range(0, 5) == 0);
          a      = $urandom;
          b      = $urandom;
        end
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run4(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    int          cyc;
    bit          got;
    p = 64'(x) * 64'(y);
    @(negedge clk);
    #2;
    a4 = x;
    b4 = y;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (done4) got = 1'b1;
      else if (busy4) cyc++;
    end
    chk("step4_done_seen", {63'b0, got}, 64'd1);
    chk("step4_busy_cycles", 64'(cyc), 64'd8);
    #2;
    lohi4 = 1'b0;
    #1;
    chk("step4_lo", {32'b0, rd_data4}, {32'b0, p[31:0]});
    lohi4 = 1'b1;
    #1;
    chk("step4_hi", {32'b0, rd_data4}, {32'b0, p[63:32]});
  endtask

  initial begin
    int cyc;
    int done_seen;
    logic [W-1:0] x, y;
    reset = 1'b0; start = 1'b0; rd_req = 1'b0; lohi = 1'b0; a = '0; b = '0;
    start4 = 1'b0; lohi4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);

    // T1: reset pulse while idle
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t1_busy", {63'b0, busy}, 64'd0);
    chk("t1_done", {63'b0, done}, 64'd0);
    chk("t1_stall", {63'b0, stall}, 64'd0);
    #2;
    read_chk("t1_lo", 1'b0, 64'd0);
    read_chk("t1_hi", 1'b1, 64'd0);

    // T2 + T4: 3*5 with a read held during RUN
    @(negedge clk);
    #2;
    issue(32'd3, 32'd5);
    rd_req = 1'b1;
    lohi   = 1'b0;
    wait_done(1'b0, cyc);
    chk("t2_busy_cycles", 64'(cyc), 64'd32);
    read_chk("t4_done_lo", 1'b0, 64'd15);

    // T6: back-to-back start in the done cycle
    issue(32'h0001_0000, 32'h0001_0000);
    wait_done(1'b0, cyc);
    chk("t6_busy_cycles", 64'(cyc), 64'd32);
    read_chk("t6_lo", 1'b0, 64'h1_0000_0000);
    read_chk("t6_hi", 1'b1, 64'h1_0000_0000);

    // T3: all-ones operands
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, cyc);
    read_chk("t3_lo", 1'b0, 64'hFFFF_FFFE_0000_0001);
    read_chk("t3_hi", 1'b1, 64'hFFFF_FFFE_0000_0001);

    // random operands with random reads and ignored starts during RUN
    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 3))
        0: begin x = $urandom_range(0, 15); y = $urandom; end
        1: begin x = $urandom; y = 32'($urandom_range(0, 1)); end
        default: begin x = $urandom; y = $urandom; end
      endcase
      issue(x, y);
      wait_done(1'b1, cyc);
      chk("rnd_busy_cycles", 64'(cyc), 64'd32);
      read_chk("rnd_lo", 1'b0, model_hl);
      read_chk("rnd_hi", 1'b1, model_hl);
    end

    // T5: reset at RUN cycle 10 aborts with no done
    @(negedge clk);
    #2;
    a = 32'd7;
    b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    model_hl = '0;
    @(negedge clk);
    chk("t5_busy", {63'b0, busy}, 64'd0);
    #2;
    read_chk("t5_lo", 1'b0, 64'd0);
    read_chk("t5_hi", 1'b1, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("t5_no_done", 64'(done_seen), 64'd0);

    // STEP=4 instance
    run4(32'h0001_0000, 32'h0001_0000);
    run4($urandom, $urandom);
    run4(32'hFFFF_FFFF, 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
